// File: rtl/modexp.sv
// modexp: constant-time left-to-right square-and-multiply modular exponentiation M^E mod N
// built on a bit-serial interleaved shift-add modular multiplier.
module modexp #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic [DATA_WIDTH-1:0] modulusin,
    input  logic [DATA_WIDTH-1:0] keyin,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  ready,
    output logic                  err
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] TOP = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_m, r_n, r_e, r_r;
    logic [DATA_WIDTH:0]   r_acc;
    logic [CW-1:0]         r_cnt, r_idx;

    logic [DATA_WIDTH-1:0] w_y;
    logic [DATA_WIDTH:0]   w_n1, w_a2, w_t1, w_t2, w_t3;

    // Multiplicand is always R; the multiplier is R when squaring, M when multiplying.
    assign w_y  = (r_state == SQR) ? r_r : r_m;
    assign w_n1 = {1'b0, r_n};
    assign w_a2 = {r_acc[DATA_WIDTH-1:0], 1'b0};
    assign w_t1 = (w_a2 >= w_n1) ? w_a2 - w_n1 : w_a2;
    assign w_t2 = w_t1 + (w_y[r_cnt] ? {1'b0, r_r} : '0);
    assign w_t3 = (w_t2 >= w_n1) ? w_t2 - w_n1 : w_t2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_n     <= '0;
            r_e     <= '0;
            r_r     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            dataout <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (enable) r_state <= LOAD;
                LOAD: begin
                    r_m   <= datain;
                    r_n   <= modulusin;
                    r_e   <= keyin;
                    r_r   <= DATA_WIDTH'(1);
                    r_idx <= TOP;
                    r_cnt <= TOP;
                    r_acc <= '0;
                    err   <= 1'b0;
                    if (modulusin < DATA_WIDTH'(2)) begin
                        dataout <= '0;
                        ready   <= 1'b1;
                        r_state <= DONE;
                    end else if (datain >= modulusin) begin
                        dataout <= '0;
                        err     <= 1'b1;
                        ready   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= SQR;
                    end
                end
                SQR: begin
                    r_acc <= (r_cnt == '0) ? '0 : w_t3;
                    r_cnt <= (r_cnt == '0) ? TOP : r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_r     <= w_t3[DATA_WIDTH-1:0];
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_acc <= (r_cnt == '0) ? '0 : w_t3;
                    r_cnt <= (r_cnt == '0) ? TOP : r_cnt - 1'b1;
                    // The product is always computed; only its use depends on the key bit.
                    if (r_cnt == '0) begin
                        if (r_e[r_idx]) r_r <= w_t3[DATA_WIDTH-1:0];
                        if (r_idx == '0) begin
                            dataout <= r_e[0] ? w_t3[DATA_WIDTH-1:0] : r_r;
                            ready   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= SQR;
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        ready   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp.sv
// tb_modexp: directed and random checks of modexp at width 8 with a result scoreboard.
module tb_modexp;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] datain = '0, modulusin = '0, keyin = '0;
    logic [W-1:0] dataout;
    logic         ready, err;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_d = '0;

    modexp #(.DATA_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .datain(datain), .modulusin(modulusin), .keyin(keyin),
        .dataout(dataout), .ready(ready), .err(err)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input int m, input int n, input int e);
        exp_t x;
        int r;
        if (n < 2) x = '{d: '0, e: 1'b0, lat: 2};
        else if (m >= n) x = '{d: '0, e: 1'b1, lat: 2};
        else begin
            r = 1;
            for (int k = 0; k < e; k++) r = (r * m) % n;
            x = '{d: W'(r), e: 1'b0, lat: 2 + 2 * W * W};
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic op(input int m, input int n, input int e, input bit disturb);
        exp_t x;
        int t = 0;
        sb.push_back(model(m, n, e));
        datain = W'(m);
        modulusin = W'(n);
        keyin = W'(e);
        enable = 1'b1;
        while (!ready && t < 400) begin
            @(posedge clock);
            t++;
            #1;
            if (disturb && t == 10) datain = 8'd9;
            if (disturb && t == 20) enable = 1'b0;
            if (disturb && t == 25) enable = 1'b1;
        end
        x = sb.pop_front();
        chk("latency", t, x.lat);
        chk("ready", {31'b0, ready}, 1);
        chk("dataout", {24'b0, dataout}, {24'b0, x.d});
        chk("err", {31'b0, err}, {31'b0, x.e});
        enable = 1'b0;
        @(posedge clock);
        #1;
        chk("ready_drop", {31'b0, ready}, 0);
        chk("dataout_hold", {24'b0, dataout}, {24'b0, x.d});
        chk("err_hold", {31'b0, err}, {31'b0, x.e});
        last_d = x.d;
    endtask

    initial begin
        int seen;
        int n;
        #1;
        chk("rst_ready", {31'b0, ready}, 0);
        chk("rst_dataout", {24'b0, dataout}, 0);
        chk("rst_err", {31'b0, err}, 0);
        #11 reset = 1'b0;
        @(posedge clock);
        #1;
        op(7, 253, 5, 0);
        op(5, 11, 0, 0);
        op(254, 255, 3, 0);
        op(20, 11, 3, 0);
        op(2, 11, 10, 0);
        op(200, 1, 7, 0);
        op(7, 253, 5, 1);
        for (int i = 0; i < 3; i++) begin
            n = int'($urandom_range(255, 2));
            op(int'($urandom_range(n - 1, 0)), n, int'($urandom_range(255, 0)), 0);
        end
        op(11, 13, 7, 0);
        datain = 8'd9;
        modulusin = 8'd100;
        keyin = 8'd3;
        enable = 1'b1;
        repeat (60) @(posedge clock);
        #1;
        chk("pre_rst_ready", {31'b0, ready}, 0);
        chk("pre_rst_hold", {24'b0, dataout}, {24'b0, last_d});
        reset = 1'b1;
        #1;
        chk("async_ready", {31'b0, ready}, 0);
        chk("async_dataout", {24'b0, dataout}, 0);
        chk("async_err", {31'b0, err}, 0);
        enable = 1'b0;
        #3 reset = 1'b0;
        seen = 0;
        repeat (200) begin
            @(posedge clock);
            #1;
            if (ready) seen++;
        end
        chk("no_ready_after_rst", seen, 0);
        op(9, 100, 3, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
